// File: rtl/cnn_stream_driver.sv
// ============================================================================
// Module   : cnn_stream_driver
// Brief    : ap_ctrl_hs master for the hls4ml CNN core. It forwards one crop
//            into the CNN input stream and unpacks the output beat into
//            predictions. Optional watchdog: define CNN_DRV_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_stream_driver #(
    parameter int PIX_W       = 8,
    parameter int NUM_PIX     = 2304,
    parameter int NUM_OUT     = 5,
    parameter int OUT_W       = 22,
    parameter int LANE_W      = 32,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [PIX_W-1:0]          s_pix_tdata,
    input  logic                      s_pix_tvalid,
    output logic                      s_pix_tready,
    input  logic                      s_pix_tlast,
    output logic                      cnn_ap_start,
    input  logic                      cnn_ap_idle,
    output logic [PIX_W-1:0]          cnn_in_tdata,
    output logic                      cnn_in_tvalid,
    input  logic                      cnn_in_tready,
    input  logic [NUM_OUT*LANE_W-1:0] cnn_out_tdata,
    input  logic                      cnn_out_tvalid,
    output logic                      cnn_out_tready,
    output logic [NUM_OUT*OUT_W-1:0]  pred_data,
    output logic                      pred_valid,
    input  logic                      pred_ready,
    output logic [15:0]               frame_cnt,
    output logic                      err_len,
    output logic                      err_timeout
);

    localparam int CNT_W = $clog2(NUM_PIX);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_STREAM   = 3'd2;
    localparam logic [2:0] S_WAIT_OUT = 3'd3;
    localparam logic [2:0] S_RESULT   = 3'd4;

    logic [2:0]               r_state;
    logic [CNT_W-1:0]         r_pix_cnt;
    logic [15:0]              r_frame_cnt;
    logic [NUM_OUT*OUT_W-1:0] r_pred;
    logic                     r_err_len;

    logic                     w_stream;
    logic                     w_pix_hs;
    logic                     w_last_pix;
    logic                     w_timeout;
    logic [NUM_OUT*OUT_W-1:0] w_pred_next;
    logic [NUM_OUT-1:0]       w_unused_lane_hi;

    assign w_stream   = (r_state == S_STREAM);
    assign w_pix_hs   = w_stream && s_pix_tvalid && cnn_in_tready;
    assign w_last_pix = (r_pix_cnt == CNT_W'(NUM_PIX - 1));

    // Only the low OUT_W bits of each lane carry the ap_fixed value.
    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
            assign w_pred_next[k*OUT_W +: OUT_W] = cnn_out_tdata[k*LANE_W +: OUT_W];
            assign w_unused_lane_hi[k]           = ^cnn_out_tdata[k*LANE_W+OUT_W +: LANE_W-OUT_W];
        end
    endgenerate

    assign s_pix_tready   = w_stream && cnn_in_tready;
    assign cnn_in_tvalid  = w_stream && s_pix_tvalid;
    assign cnn_in_tdata   = w_stream ? s_pix_tdata : '0;
    assign cnn_ap_start   = (r_state == S_START);
    assign cnn_out_tready = (r_state == S_WAIT_OUT);
    assign pred_valid     = (r_state == S_RESULT);
    assign pred_data      = r_pred;
    assign frame_cnt      = r_frame_cnt;
    assign err_len        = r_err_len;

`ifdef CNN_DRV_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err_timeout;

    // Beat arrival wins over expiry when both land on the same cycle.
    assign w_timeout = (r_state == S_WAIT_OUT) && !cnn_out_tvalid
                       && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state == S_WAIT_OUT) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end else begin
                r_wd_cnt <= '0;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_timeout        = 1'b0;
    assign err_timeout      = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= S_IDLE;
            r_pix_cnt   <= '0;
            r_frame_cnt <= '0;
            r_pred      <= '0;
            r_err_len   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_pix_tvalid && cnn_ap_idle) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_pix_cnt <= '0;
                    r_state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_pix_hs) begin
                        r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                        // The pixel count alone terminates the frame; tlast is only audited.
                        if (s_pix_tlast != w_last_pix) begin
                            r_err_len <= 1'b1;
                        end
                        if (w_last_pix) begin
                            r_state <= S_WAIT_OUT;
                        end
                    end
                end
                S_WAIT_OUT: begin
                    if (cnn_out_tvalid) begin
                        r_pred  <= w_pred_next;
                        r_state <= S_RESULT;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RESULT: begin
                    if (pred_ready) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cnn_stream_driver.sv
// ============================================================================
// Module   : tb_cnn_stream_driver
// Brief    : Scoreboard bench for cnn_stream_driver (directed frames).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_stream_driver;

    localparam int NUM_PIX = 2304;
    localparam int NUM_OUT = 5;
    localparam int OUT_W   = 22;
    localparam int LANE_W  = 32;

    logic                      ap_clk = 1'b0;
    logic                      ap_rst;
    logic [7:0]                s_pix_tdata;
    logic                      s_pix_tvalid;
    logic                      s_pix_tready;
    logic                      s_pix_tlast;
    logic                      cnn_ap_start;
    logic                      cnn_ap_idle;
    logic [7:0]                cnn_in_tdata;
    logic                      cnn_in_tvalid;
    logic                      cnn_in_tready;
    logic [NUM_OUT*LANE_W-1:0] cnn_out_tdata;
    logic                      cnn_out_tvalid;
    logic                      cnn_out_tready;
    logic [NUM_OUT*OUT_W-1:0]  pred_data;
    logic                      pred_valid;
    logic                      pred_ready;
    logic [15:0]               frame_cnt;
    logic                      err_len;
    logic                      err_timeout;

    always #5 ap_clk = ~ap_clk;

    cnn_stream_driver #(
        .PIX_W      (8),
        .NUM_PIX    (NUM_PIX),
        .NUM_OUT    (NUM_OUT),
        .OUT_W      (OUT_W),
        .LANE_W     (LANE_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .s_pix_tdata   (s_pix_tdata),
        .s_pix_tvalid  (s_pix_tvalid),
        .s_pix_tready  (s_pix_tready),
        .s_pix_tlast   (s_pix_tlast),
        .cnn_ap_start  (cnn_ap_start),
        .cnn_ap_idle   (cnn_ap_idle),
        .cnn_in_tdata  (cnn_in_tdata),
        .cnn_in_tvalid (cnn_in_tvalid),
        .cnn_in_tready (cnn_in_tready),
        .cnn_out_tdata (cnn_out_tdata),
        .cnn_out_tvalid(cnn_out_tvalid),
        .cnn_out_tready(cnn_out_tready),
        .pred_data     (pred_data),
        .pred_valid    (pred_valid),
        .pred_ready    (pred_ready),
        .frame_cnt     (frame_cnt),
        .err_len       (err_len),
        .err_timeout   (err_timeout)
    );

    int n_chk = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int start_cnt = 0;
    logic [7:0]               q_pix[$];
    logic [NUM_OUT*OUT_W-1:0] q_pred[$];

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: pops the expected pixel/prediction on every DUT handshake.
    always @(negedge ap_clk) begin
        if (cnn_ap_start) start_cnt++;
        if (cnn_in_tvalid && cnn_in_tready) begin
            hs_cnt++;
            if (q_pix.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL pix_extra: got %h expected no handshake", cnn_in_tdata);
            end else begin
                chk("pix_data", 128'(cnn_in_tdata), 128'(q_pix.pop_front()));
            end
        end
        if (pred_valid && pred_ready) begin
            if (q_pred.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL pred_extra: got %h expected no handshake", pred_data);
            end else begin
                chk("pred_data", 128'(pred_data), 128'(q_pred.pop_front()));
            end
        end
    end

    task automatic send_frame(input int tlast_pos, input bit toggle, input int abort_at);
        int  idx = 0;
        int  cyc = 0;
        int  stop;
        bit  hs;
        stop = (abort_at > 0) ? abort_at : NUM_PIX;
        for (int i = 0; i < stop; i++) q_pix.push_back(i[7:0]);
        while (idx < stop && cyc < 20000) begin
            s_pix_tvalid  = 1'b1;
            s_pix_tdata   = idx[7:0];
            s_pix_tlast   = (idx == tlast_pos);
            cnn_in_tready = toggle ? ~cnn_in_tready : 1'b1;
            @(negedge ap_clk);
            hs = s_pix_tready;
            @(posedge ap_clk);
            #1;
            if (hs) idx++;
            cyc++;
        end
        if (idx < stop) begin
            n_chk++;
            n_err++;
            $display("FAIL send_frame_timeout: accepted %0d expected %0d", idx, stop);
        end
        s_pix_tvalid  = 1'b0;
        s_pix_tlast   = 1'b0;
        cnn_in_tready = 1'b1;
    endtask

    task automatic cnn_respond(input logic [NUM_OUT*LANE_W-1:0] beat,
                               input logic [NUM_OUT*OUT_W-1:0] exp);
        int cyc = 0;
        bit hs = 1'b0;
        q_pred.push_back(exp);
        cnn_out_tdata  = beat;
        cnn_out_tvalid = 1'b1;
        while (!hs && cyc < 1000) begin
            @(negedge ap_clk);
            hs = cnn_out_tready;
            @(posedge ap_clk);
            #1;
            cyc++;
        end
        if (!hs) begin
            n_chk++;
            n_err++;
            $display("FAIL cnn_out_timeout: got no cnn_out_tready expected handshake");
        end
        cnn_out_tvalid = 1'b0;
        cnn_out_tdata  = '0;
        @(negedge ap_clk);
        chk("pred_latency", 128'(pred_valid), 128'(1));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ap_start"},   128'(cnn_ap_start),   0);
        chk({tag, "_pix_tready"}, 128'(s_pix_tready),   0);
        chk({tag, "_in_tvalid"},  128'(cnn_in_tvalid),  0);
        chk({tag, "_in_tdata"},   128'(cnn_in_tdata),   0);
        chk({tag, "_out_tready"}, 128'(cnn_out_tready), 0);
        chk({tag, "_pred_valid"}, 128'(pred_valid),     0);
        chk({tag, "_pred_data"},  128'(pred_data),      0);
        chk({tag, "_frame_cnt"},  128'(frame_cnt),      0);
        chk({tag, "_err_len"},    128'(err_len),        0);
        chk({tag, "_err_timeout"},128'(err_timeout),    0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [NUM_OUT*LANE_W-1:0] beat_a, beat_b, beat_c;
        logic [NUM_OUT*OUT_W-1:0]  exp_a, exp_b, exp_c;
        int base_h, base_s;
        int wd;

        for (int k = 0; k < NUM_OUT; k++) begin
            beat_a[k*LANE_W +: LANE_W] = 32'h000A_BCDE + k;
            exp_a[k*OUT_W +: OUT_W]    = 22'h0A_BCDE + k;
        end
        beat_b = {32'h003F_FFFE, 32'hFFC0_0001, 32'h0000_0000, 32'h0020_0000, 32'hFFFF_FFFF};
        exp_b  = {22'h3F_FFFE,   22'h00_0001,   22'h00_0000,   22'h20_0000,   22'h3F_FFFF};
        beat_c = {32'h5551_2345, 32'hAAA0_0FFF, 32'h1234_5678, 32'h8000_0001, 32'h0015_5555};
        exp_c  = {22'h11_2345,   22'h20_0FFF,   22'h34_5678,   22'h00_0001,   22'h15_5555};

        ap_rst         = 1'b1;
        s_pix_tdata    = '0;
        s_pix_tvalid   = 1'b0;
        s_pix_tlast    = 1'b0;
        cnn_ap_idle    = 1'b1;
        cnn_in_tready  = 1'b1;
        cnn_out_tdata  = '0;
        cnn_out_tvalid = 1'b0;
        pred_ready     = 1'b1;
        idle_cycles(3);
        @(negedge ap_clk);
        check_zero("reset");
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;

        // CNN busy: pending pixel must not trigger a start.
        cnn_ap_idle  = 1'b0;
        s_pix_tvalid = 1'b1;
        repeat (4) begin
            @(negedge ap_clk);
            chk("busy_ap_start", 128'(cnn_ap_start), 0);
            chk("busy_pix_tready", 128'(s_pix_tready), 0);
        end
        @(posedge ap_clk);
        #1;
        cnn_ap_idle = 1'b1;

        // Frame 1: nominal.
        base_h = hs_cnt; base_s = start_cnt;
        send_frame(NUM_PIX - 1, 1'b0, 0);
        chk("f1_handshakes", 128'(hs_cnt - base_h), 128'(NUM_PIX));
        chk("f1_starts", 128'(start_cnt - base_s), 1);
        cnn_respond(beat_a, exp_a);
        idle_cycles(2);
        chk("f1_frame_cnt", 128'(frame_cnt), 1);
        chk("f1_err_len", 128'(err_len), 0);

        // Frame 2: input ready toggling every cycle.
        base_h = hs_cnt; base_s = start_cnt;
        send_frame(NUM_PIX - 1, 1'b1, 0);
        chk("f2_handshakes", 128'(hs_cnt - base_h), 128'(NUM_PIX));
        chk("f2_starts", 128'(start_cnt - base_s), 1);
        cnn_respond(beat_b, exp_b);
        idle_cycles(2);
        chk("f2_frame_cnt", 128'(frame_cnt), 2);
        chk("f2_err_len", 128'(err_len), 0);

        // Frame 3: early tlast; count still ends the frame, extra pixel stalls.
        base_h = hs_cnt;
        send_frame(2000, 1'b0, 0);
        chk("f3_handshakes", 128'(hs_cnt - base_h), 128'(NUM_PIX));
        chk("f3_err_len", 128'(err_len), 1);
        s_pix_tvalid = 1'b1;
        s_pix_tdata  = 8'h5A;
        repeat (8) begin
            @(negedge ap_clk);
            chk("f3_extra_tready", 128'(s_pix_tready), 0);
            chk("f3_extra_tvalid", 128'(cnn_in_tvalid), 0);
        end
        @(posedge ap_clk);
        #1;
        s_pix_tvalid = 1'b0;
        cnn_respond(beat_a, exp_a);
        idle_cycles(2);
        chk("f3_frame_cnt", 128'(frame_cnt), 3);

        // Frame 4: consumer back-pressure with stray beat and pending pixel.
        pred_ready = 1'b0;
        send_frame(NUM_PIX - 1, 1'b0, 0);
        cnn_respond(beat_c, exp_c);
        cnn_out_tvalid = 1'b1;
        cnn_out_tdata  = ~beat_c;
        s_pix_tvalid   = 1'b1;
        repeat (100) begin
            @(negedge ap_clk);
            chk("hold_pred_valid", 128'(pred_valid), 1);
            chk("hold_pred_data", 128'(pred_data), 128'(exp_c));
            chk("hold_out_tready", 128'(cnn_out_tready), 0);
            chk("hold_pix_tready", 128'(s_pix_tready), 0);
        end
        @(posedge ap_clk);
        #1;
        cnn_out_tvalid = 1'b0;
        cnn_out_tdata  = '0;
        s_pix_tvalid   = 1'b0;
        pred_ready     = 1'b1;
        idle_cycles(2);
        chk("f4_frame_cnt", 128'(frame_cnt), 4);

        // Frame 5: reset mid-frame, then a clean frame.
        send_frame(NUM_PIX - 1, 1'b0, 1000);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check_zero("midrst");
        @(posedge ap_clk);
        #1;
        base_h = hs_cnt;
        send_frame(NUM_PIX - 1, 1'b0, 0);
        chk("f5_handshakes", 128'(hs_cnt - base_h), 128'(NUM_PIX));
        cnn_respond(beat_b, exp_b);
        idle_cycles(2);
        chk("f5_frame_cnt", 128'(frame_cnt), 1);
        chk("f5_err_len", 128'(err_len), 0);

        // Frame 6: missing tlast, then watchdog (or plain response without it).
        send_frame(-1, 1'b0, 0);
        chk("f6_err_len", 128'(err_len), 1);
`ifdef CNN_DRV_TIMEOUT_EN
        wd = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge ap_clk);
            if (!cnn_out_tready) break;
            wd++;
        end
        chk("wd_cycles", 128'(wd), 16);
        chk("wd_err_timeout", 128'(err_timeout), 1);
        chk("wd_pred_valid", 128'(pred_valid), 0);
        chk("wd_pred_data", 128'(pred_data), 128'(exp_b));
        chk("wd_frame_cnt", 128'(frame_cnt), 1);
`else
        wd = 0;
        cnn_respond(beat_c, exp_c);
        idle_cycles(2);
        chk("f6_err_timeout", 128'(err_timeout), 128'(wd));
        chk("f6_frame_cnt", 128'(frame_cnt), 2);
`endif
        idle_cycles(2);
        chk("pix_queue_left", 128'(q_pix.size()), 0);
        chk("pred_queue_left", 128'(q_pred.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
